// File: rtl/booth_issue_ctrl.sv
// Operand-issue / result-capture controller wrapped around an 8x8 Booth multiplier.
// Buffers operand pairs in a FIFO, issues them one at a time and returns products in order.
module booth_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_mc,
    input  logic [7:0]  in_mp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic [7:0]  mul_mc,
    output logic [7:0]  mul_mp,
    output logic        mul_start,
    input  logic [15:0] mul_prod,
    input  logic        mul_busy,
    output logic        err
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned DW   = 8;
    localparam int unsigned PRW  = 16;
    localparam int unsigned WD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_d;

    logic [DW-1:0]   fifo_mc [FIFO_DEPTH];
    logic [DW-1:0]   fifo_mp [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_d;
    logic [DW-1:0]   mc_d;
    logic [DW-1:0]   mp_d;
    logic            start_d;
    logic            ov_d;
    logic            err_d;
    logic [PRW-1:0]  prod_d;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mc[wr_ptr[AW-1:0]] <= in_mc;
            fifo_mp[wr_ptr[AW-1:0]] <= in_mp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mul_mc    <= '0;
            mul_mp    <= '0;
            mul_start <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            err       <= 1'b0;
            wd        <= '0;
        end else begin
            state     <= state_d;
            mul_mc    <= mc_d;
            mul_mp    <= mp_d;
            mul_start <= start_d;
            out_valid <= ov_d;
            out_prod  <= prod_d;
            err       <= err_d;
            wd        <= wd_d;
        end
    end

    // wd is zero only on the first WAIT cycle, where busy has not yet been driven valid.
    always_comb begin
        state_d = state;
        mc_d    = mul_mc;
        mp_d    = mul_mp;
        start_d = 1'b0;
        ov_d    = out_valid;
        prod_d  = out_prod;
        err_d   = err;
        wd_d    = wd;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    mc_d    = fifo_mc[rd_ptr[AW-1:0]];
                    mp_d    = fifo_mp[rd_ptr[AW-1:0]];
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if ((wd != '0) && !mul_busy) begin
                    prod_d  = mul_prod;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else if ((wd + WD_W'(1)) == WD_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd + WD_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
